// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and load clamp helper for the mod-N up/down counter
package counter_pkg;

    localparam logic DIR_UP     = 1'b1;
    localparam logic DIR_DOWN   = 1'b0;
    localparam int   WRAP_CNT_W = 8;

    // Out-of-range load values saturate to the top of the count range.
    function automatic int clamp_load(input int value, input int modulus);
        return (value < modulus) ? value : modulus - 1;
    endfunction

endpackage

// File: rtl/counter_tff_cell.sv
// rtl/counter_tff_cell.sv - single toggle flip-flop bit with async active-low reset and sync load
module counter_tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic d,
    input  logic t,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= 1'b0;
        end else if (load) begin
            r_q <= d;
        end else if (t) begin
            r_q <= ~r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/mod_n_updown_counter.sv
// rtl/mod_n_updown_counter.sv - mod-N up/down counter with load and terminal count; MOD_COUNTER_WRAP_COUNT_EN adds wrap_count
module mod_n_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] out,
    output logic             loop_end
`ifdef MOD_COUNTER_WRAP_COUNT_EN
    ,
    output logic [WRAP_CNT_W-1:0] wrap_count
`endif
);

    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("mod_n_updown_counter: WIDTH must be 1..16");
    end
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("mod_n_updown_counter: MODULUS must be 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_up_t;
    logic [WIDTH-1:0] w_dn_t;
    logic [WIDTH-1:0] w_toggle;
    logic             w_at_term;

    assign w_load_val = WIDTH'(clamp_load(int'(load_value), MODULUS));
    assign w_at_term  = (up == DIR_UP) ? (w_q == MAX_VAL) : (w_q == '0);

    // Ripple carry/borrow chain: a bit toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        w_up_t    = '0;
        w_dn_t    = '0;
        w_up_t[0] = 1'b1;
        w_dn_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            w_up_t[i] = w_up_t[i-1] & w_q[i-1];
            w_dn_t[i] = w_dn_t[i-1] & ~w_q[i-1];
        end
    end

    // At the terminal value, toggle exactly the bits that differ from the wrap target.
    always_comb begin
        w_toggle = '0;
        if (enable) begin
            if (w_at_term) begin
                w_toggle = (up == DIR_UP) ? w_q : (w_q ^ MAX_VAL);
            end else begin
                w_toggle = (up == DIR_UP) ? w_up_t : w_dn_t;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        counter_tff_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .load  (load),
            .d     (w_load_val[i]),
            .t     (w_toggle[i]),
            .q     (w_q[i])
        );
    end

    assign out      = w_q;
    assign loop_end = reset & enable & ~load & w_at_term;

`ifdef MOD_COUNTER_WRAP_COUNT_EN
    logic [WRAP_CNT_W-1:0] r_wrap_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrap_cnt <= '0;
        end else if (load) begin
            r_wrap_cnt <= '0;
        end else if (loop_end) begin
            r_wrap_cnt <= r_wrap_cnt + 1'b1;
        end
    end

    assign wrap_count = r_wrap_cnt;
`endif

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// tb/tb_mod_n_updown_counter.sv - scoreboard bench for mod_n_updown_counter (WIDTH 4, MODULUS 10)
module tb_mod_n_updown_counter;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] out;
    logic         loop_end;
`ifdef MOD_COUNTER_WRAP_COUNT_EN
    logic [7:0]   wrap_count;
`endif

    mod_n_updown_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .up         (up),
        .load       (load),
        .load_value (load_value),
        .out        (out),
        .loop_end   (loop_end)
`ifdef MOD_COUNTER_WRAP_COUNT_EN
        ,
        .wrap_count (wrap_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int o;
        int wc;
    } exp_t;

    exp_t oq[$];
    bit   lq[$];
    int   m = 0;
    int   wcm = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and push what the model predicts.
    task automatic step(input bit rn, input bit en, input bit u, input bit ld, input int lv);
        bit le;
        exp_t e;
        @(negedge clk);
        reset      = rn;
        enable     = en;
        up         = u;
        load       = ld;
        load_value = W'(lv);
        le = 1'b0;
        if (!rn) begin
            m   = 0;
            wcm = 0;
        end else begin
            le = en && !ld && (u ? (m == M - 1) : (m == 0));
            if (ld) begin
                m   = (lv < M) ? lv : M - 1;
                wcm = 0;
            end else begin
                if (en) m = u ? (m + 1) % M : (m + M - 1) % M;
                if (le) wcm = (wcm + 1) % 256;
            end
        end
        lq.push_back(le);
        e.o  = m;
        e.wc = wcm;
        oq.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (oq.size() > 0) begin
            e = oq.pop_front();
            check("out", int'(out), e.o);
`ifdef MOD_COUNTER_WRAP_COUNT_EN
            check("wrap_count", int'(wrap_count), e.wc);
`endif
        end
    end

    always @(negedge clk) begin
        #3;
        if (lq.size() > 0) check("loop_end", int'(loop_end), int'(lq.pop_front()));
    end

    initial begin
        #1;
        check("reset_out", int'(out), 0);
        check("reset_loop_end", int'(loop_end), 0);

        repeat (3) step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);

        step(1, 1, 1, 1, 0);
        repeat (12) step(1, 1, 1, 0, 0);

        step(1, 1, 1, 1, 2);
        repeat (4) step(1, 1, 0, 0, 0);

        step(1, 1, 1, 1, 7);
        step(1, 1, 0, 1, 14);
        step(1, 1, 1, 1, 15);

        step(1, 0, 1, 1, 4);
        repeat (5) step(1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0);

        step(1, 1, 1, 1, 0);
        repeat (6) step(1, 1, 1, 0, 0);
        check("pre_reset_model", m, 6);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_out", int'(out), 0);
        check("async_reset_loop_end", int'(loop_end), 0);
        m   = 0;
        wcm = 0;
        repeat (2) step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);

`ifdef MOD_COUNTER_WRAP_COUNT_EN
        step(1, 1, 1, 1, 0);
        repeat (M * 260) step(1, 1, 1, 0, 0);
        @(posedge clk);
        #2;
        check("wrap_count_260", int'(wrap_count), 4);
        step(1, 1, 1, 1, 3);
        @(posedge clk);
        #2;
        check("wrap_count_load_clear", int'(wrap_count), 0);
`endif

        repeat (3000) begin
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 15)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", oq.size() + lq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mod_n_updown_counter.md
Name: mod_n_updown_counter

Overview:
- Parametrised synchronous counter; next generation of the fixed 3-bit T-flip-flop counter.
- Adds: configurable width and modulus, up/down mode, parallel load, count enable, terminal-count (loop_end) flag.
- Used as the sequencing/timing counter in the datapath controllers; loop_end chains counters into cascades.

Parameters:
- WIDTH, 3, counter width in bits; legal range 1..16.
- MODULUS, 8, count range is 0..MODULUS-1; legal range 2..2**WIDTH; elaboration error outside this range.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous active-low reset.
- enable  input  1  count enable; high = advance one step per clk.
- up  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load strobe.
- load_value  input  WIDTH  value written on load.
- out  output  WIDTH  current count (registered).
- loop_end  output  1  terminal-count flag (combinational from state and inputs).
- wrap_count  output  8  number of wraps (present only with WRAP_COUNT_EN).

Behaviour:
- Reset (reset = 0, asynchronous, immediate): out = 0; wrap_count = 0; loop_end = 0 while reset is low. Release is synchronous to clk. Reset asserted mid-count aborts the count with no partial state.
- Priority per rising edge: load > enable > hold.
- Load (load = 1): out <= load_value when load_value < MODULUS, else out <= MODULUS-1 (clamp). Load ignores enable and up.
- Up count (load = 0, enable = 1, up = 1):
  - out <= out+1.
  - At MODULUS-1, out <= 0 (wrap).
- Down count (load = 0, enable = 1, up = 0):
  - out <= out-1.
  - At 0, out <= MODULUS-1 (wrap).
- Hold (load = 0, enable = 0): out unchanged.
- loop_end = reset & enable & ~load & (up ? out == MODULUS-1 : out == 0).
  - High exactly in the cycle before a wrap edge.
  - A cascade stage uses it as its enable.
- Latency:
  - out updates 1 clk after the qualifying edge.
  - loop_end follows input changes in the same cycle.
- Direction change takes effect on the next edge. Example: out = 5 with up falling gives out = 4 on that edge.
- If MODULUS = 2**WIDTH, wrap is natural overflow and behaviour is identical.
- Illegal out values cannot occur: load clamps, and reset forces 0.

Optional Feature:
- Macro: MOD_COUNTER_WRAP_COUNT_EN.
- Defined:
  - wrap_count port exists.
  - 8-bit register increments on every edge where loop_end = 1; wraps 255 -> 0.
  - Cleared by reset and by load.
- Undefined: port and register are absent; all other behaviour is identical.

Decomposition:
- Package counter_pkg holds:
  - direction constants DIR_UP = 1'b1, DIR_DOWN = 1'b0.
  - wrap counter width constant WRAP_CNT_W = 8.
  - function clamp_load(value, modulus).
- One natural sub-module: counter_tff_cell, a single T-flip-flop bit with async active-low reset and synchronous load.
  - The counter instantiates WIDTH cells.
  - Per-bit toggle terms come from the up/down carry chain, overridden at wrap.

Test Plan:
- Reset: hold reset = 0 for 3 clk with enable = 1, then release. out = 0 during reset and on release; first enabled edge gives out = 1. Assert reset mid-count at out = 6: out = 0 immediately, without waiting for clk.
- Up wrap, WIDTH = 4, MODULUS = 10, up = 1, enable = 1 for 12 clk: out runs 0..9, 0, 1. loop_end is high only while out = 9.
- Down wrap, same config, up = 0 from out = 2: out goes 1, 0, 9, 8. loop_end is high only while out = 0.
- Load priority and clamp:
  - load = 1, enable = 1, load_value = 7: out = 7 next clk, no count.
  - load_value = 14 with MODULUS = 10: out = 9.
  - loop_end = 0 in every cycle where load = 1.
- Hold and direction change:
  - enable = 0 for 5 clk at out = 4: out stays 4, loop_end = 0.
  - Toggle up at out = 5: next out = 4.
- With MOD_COUNTER_WRAP_COUNT_EN, default parameters: 8*260 enabled clk gives wrap_count = 260 mod 256 = 4. Then load gives wrap_count = 0.
